// File: rtl/crypto_req_dispatch.sv
// crypto_req_dispatch: accelerator-side endpoint for the decode stage's crypto
// request lines. Edge-detects H/E/D requests, holds one extra request in a
// pending slot, drives the engine through a start/done pulse handshake, returns
// a one-cycle completion pulse per op, and forces completion if the engine
// never answers.
//
// Engine handshake: eng_start is a one-cycle launch pulse with eng_op/eng_index
// valid in that cycle and held until the completion pulse has been sent; the
// engine answers with a one-cycle eng_done, which is honoured only while the
// dispatcher is waiting for it and ignored at any other time.
module crypto_req_dispatch #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        H_int,
    input  logic        E_int,
    input  logic        D_int,
    input  logic [10:0] index,
    input  logic        eng_done,
    output logic        eng_start,
    output logic [1:0]  eng_op,
    output logic [10:0] eng_index,
    output logic        H_done,
    output logic        E_done,
    output logic        D_done,
    output logic        busy,
    output logic        timeout_err,
    output logic        ovf_err
);

    localparam logic [1:0]       OP_H     = 2'b01;
    localparam logic [1:0]       OP_E     = 2'b10;
    localparam logic [1:0]       OP_D     = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state;
    logic             h_q, e_q, d_q;
    logic             req_h, req_e, req_d;
    logic             req_any, req_multi;
    logic [1:0]       req_op;
    logic             pend_valid;
    logic [1:0]       pend_op;
    logic [10:0]      pend_index;
    logic [CNT_W-1:0] cnt;
    logic             wait_fire;
    logic             wait_tmo;

    assign req_h = H_int & ~h_q;
    assign req_e = E_int & ~e_q;
    assign req_d = D_int & ~d_q;

    // Previous request levels, so a held level counts as one request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q <= 1'b0;
            e_q <= 1'b0;
            d_q <= 1'b0;
        end else begin
            h_q <= H_int;
            e_q <= E_int;
            d_q <= D_int;
        end
    end

    // Pick the winning new request (H > E > D) and flag simultaneous ones.
    always_comb begin
        req_any   = req_h | req_e | req_d;
        req_multi = (req_h & req_e) | (req_h & req_d) | (req_e & req_d);
        req_op    = 2'b00;
        if (req_h) begin
            req_op = OP_H;
        end else if (req_e) begin
            req_op = OP_E;
        end else if (req_d) begin
            req_op = OP_D;
        end
    end

    // A WAIT cycle ends the op on engine completion or on the last allowed cycle.
    always_comb begin
        wait_tmo  = (state == S_WAIT) && !eng_done && (cnt == CNT_LAST);
        wait_fire = (state == S_WAIT) && (eng_done || (cnt == CNT_LAST));
    end

    assign busy = (state != S_IDLE) || pend_valid;

    // Dispatch FSM, pending slot, watchdog counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pend_valid  <= 1'b0;
            pend_op     <= 2'b00;
            pend_index  <= 11'd0;
            cnt         <= '0;
            eng_start   <= 1'b0;
            eng_op      <= 2'b00;
            eng_index   <= 11'd0;
            H_done      <= 1'b0;
            E_done      <= 1'b0;
            D_done      <= 1'b0;
            timeout_err <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            H_done    <= 1'b0;
            E_done    <= 1'b0;
            D_done    <= 1'b0;
            if (req_multi) begin
                ovf_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (pend_valid) begin
                        state     <= S_LAUNCH;
                        eng_start <= 1'b1;
                        eng_op    <= pend_op;
                        eng_index <= pend_index;
                        // The slot is freed and refilled in the same cycle.
                        if (req_any) begin
                            pend_op    <= req_op;
                            pend_index <= index;
                        end else begin
                            pend_valid <= 1'b0;
                        end
                    end else if (req_any) begin
                        state     <= S_LAUNCH;
                        eng_start <= 1'b1;
                        eng_op    <= req_op;
                        eng_index <= index;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                    cnt   <= '0;
                end
                S_WAIT: begin
                    if (wait_fire) begin
                        state  <= S_DONE;
                        H_done <= (eng_op == OP_H);
                        E_done <= (eng_op == OP_E);
                        D_done <= (eng_op == OP_D);
                        if (wait_tmo) begin
                            timeout_err <= 1'b1;
                        end
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    eng_op    <= 2'b00;
                    eng_index <= 11'd0;
                end
                default: state <= S_IDLE;
            endcase
            // Requests arriving mid-op go to the pending slot or are dropped.
            if ((state != S_IDLE) && req_any) begin
                if (!pend_valid) begin
                    pend_valid <= 1'b1;
                    pend_op    <= req_op;
                    pend_index <= index;
                end else begin
                    ovf_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_crypto_req_dispatch.sv
// tb_crypto_req_dispatch: directed scenarios plus a randomized run against a
// transaction-level reference model of the dispatcher.
module tb_crypto_req_dispatch;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        H_int, E_int, D_int;
    logic [10:0] index;
    logic        eng_done;
    logic        eng_start;
    logic [1:0]  eng_op;
    logic [10:0] eng_index;
    logic        H_done, E_done, D_done;
    logic        busy, timeout_err, ovf_err;

    int          checks   = 0;
    int          failures = 0;
    logic [19:0] obs;
    logic [19:0] exp_v;

    crypto_req_dispatch #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .H_int(H_int), .E_int(E_int), .D_int(D_int),
        .index(index), .eng_done(eng_done), .eng_start(eng_start), .eng_op(eng_op),
        .eng_index(eng_index), .H_done(H_done), .E_done(E_done), .D_done(D_done),
        .busy(busy), .timeout_err(timeout_err), .ovf_err(ovf_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {eng_start, eng_op, eng_index, H_done, E_done, D_done, busy, timeout_err, ovf_err};

    function automatic logic [19:0] vec(logic st, logic [1:0] op, logic [10:0] idx, logic hd,
                                        logic ed, logic dd, logic bsy, logic to, logic ov);
        return {st, op, idx, hd, ed, dd, bsy, to, ov};
    endfunction

    // Driver tasks
    task automatic set_in(input logic h, input logic e, input logic d,
                          input logic [10:0] idx, input logic dn);
        H_int    = h;
        E_int    = e;
        D_int    = d;
        index    = idx;
        eng_done = dn;
    endtask

    task automatic next_cyc;
        @(negedge clk);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 11'h7FF, 1'b1);
        repeat (3) next_cyc;
        exp_v = '0; checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_outputs got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
        rst_n = 1'b1;
        next_cyc;
        exp_v = '0; checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_idle got=%05h want=%05h", obs, exp_v); end
    endtask

    task automatic test_single_hash;
        apply_reset;
        set_in(1'b1, 1'b0, 1'b0, 11'h2A5, 1'b0);
        next_cyc;
        exp_v = vec(1'b1, 2'b01, 11'h2A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL hash_launch got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 11'h155, 1'b0);
        next_cyc;
        exp_v = vec(1'b0, 2'b01, 11'h2A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL hash_wait got=%05h want=%05h", obs, exp_v); end
        next_cyc;
        next_cyc;
        set_in(1'b0, 1'b0, 1'b0, 11'h0F0, 1'b1);
        next_cyc;
        exp_v = vec(1'b0, 2'b01, 11'h2A5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL hash_done got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 11'h0F0, 1'b0);
        next_cyc;
        exp_v = '0; checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL hash_idle got=%05h want=%05h", obs, exp_v); end
    endtask

    task automatic test_held_level;
        int         starts   = 0;
        int         dones    = 0;
        int         wrong    = 0;
        int         launch_c = -100;
        logic [1:0] launch_op = 2'b00;
        apply_reset;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) next_cyc;
            if (eng_start) begin starts++; launch_c = i; launch_op = eng_op; end
            if (E_done) dones++;
            if (H_done || D_done) wrong++;
            set_in(1'b0, i < 10, 1'b0, 11'($urandom), i == launch_c + 2);
        end
        next_cyc;
        checks++;
        if (starts !== 1) begin failures++; $display("FAIL held_starts got=%0d want=1", starts); end
        checks++;
        if (dones !== 1) begin failures++; $display("FAIL held_dones got=%0d want=1", dones); end
        checks++;
        if (launch_op !== 2'b10) begin failures++; $display("FAIL held_op got=%0b want=10", launch_op); end
        checks++;
        if (wrong !== 0) begin failures++; $display("FAIL held_other_done got=%0d want=0", wrong); end
        checks++;
        if ({ovf_err, busy} !== 2'b00) begin failures++; $display("FAIL held_flags got=%0b want=00", {ovf_err, busy}); end
    endtask

    task automatic test_pending_drop;
        apply_reset;
        set_in(1'b1, 1'b0, 1'b0, 11'h011, 1'b0);
        next_cyc;
        exp_v = vec(1'b1, 2'b01, 11'h011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL pend_h_launch got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 11'h7FF, 1'b0);
        next_cyc;
        set_in(1'b0, 1'b0, 1'b1, 11'h022, 1'b0);
        next_cyc;
        exp_v = vec(1'b0, 2'b01, 11'h011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL pend_d_stored got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b1, 1'b1, 11'h033, 1'b0);
        next_cyc;
        exp_v = vec(1'b0, 2'b01, 11'h011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL pend_e_dropped got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 11'h044, 1'b1);
        next_cyc;
        exp_v = vec(1'b0, 2'b01, 11'h011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL pend_h_done got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
        next_cyc;
        exp_v = vec(1'b0, 2'b00, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL pend_idle_busy got=%05h want=%05h", obs, exp_v); end
        next_cyc;
        exp_v = vec(1'b1, 2'b11, 11'h022, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL pend_d_launch got=%05h want=%05h", obs, exp_v); end
        next_cyc;
        set_in(1'b0, 1'b0, 1'b0, 11'h000, 1'b1);
        next_cyc;
        exp_v = vec(1'b0, 2'b11, 11'h022, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL pend_d_done got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
        next_cyc;
        exp_v = vec(1'b0, 2'b00, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL pend_final_idle got=%05h want=%05h", obs, exp_v); end
    endtask

    task automatic test_simultaneous;
        apply_reset;
        set_in(1'b1, 1'b0, 1'b1, 11'h155, 1'b0);
        next_cyc;
        exp_v = vec(1'b1, 2'b01, 11'h155, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL simul_launch got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
        next_cyc;
        set_in(1'b0, 1'b0, 1'b0, 11'h000, 1'b1);
        next_cyc;
        exp_v = vec(1'b0, 2'b01, 11'h155, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL simul_done got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
        next_cyc;
        exp_v = vec(1'b0, 2'b00, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL simul_idle got=%05h want=%05h", obs, exp_v); end
        next_cyc;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL simul_no_relaunch got=%05h want=%05h", obs, exp_v); end
    endtask

    task automatic test_timeout;
        apply_reset;
        set_in(1'b0, 1'b0, 1'b1, 11'h3FF, 1'b0);
        next_cyc;
        exp_v = vec(1'b1, 2'b11, 11'h3FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL tmo_launch got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
        repeat (TMO) next_cyc;
        exp_v = vec(1'b0, 2'b11, 11'h3FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL tmo_last_wait got=%05h want=%05h", obs, exp_v); end
        next_cyc;
        exp_v = vec(1'b0, 2'b11, 11'h3FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL tmo_done got=%05h want=%05h", obs, exp_v); end
        next_cyc;
        exp_v = vec(1'b0, 2'b00, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL tmo_idle got=%05h want=%05h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_op;
        apply_reset;
        set_in(1'b1, 1'b0, 1'b0, 11'h0AB, 1'b0);
        next_cyc;
        set_in(1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
        next_cyc;
        rst_n = 1'b0;
        next_cyc;
        exp_v = '0; checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL rst_mid_outputs got=%05h want=%05h", obs, exp_v); end
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 11'h000, 1'b1);
        next_cyc;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL rst_late_done got=%05h want=%05h", obs, exp_v); end
        set_in(1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
        next_cyc;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL rst_stays_idle got=%05h want=%05h", obs, exp_v); end
    endtask

    // Random run: the model tracks the op in service by its launch and
    // completion cycle numbers plus one waiting request.
    task automatic test_random(input int n_cycles);
        bit          m_active = 0, m_wv = 0, m_tout = 0, m_ovf = 0, fin;
        bit          ph = 0, pe = 0, pd = 0, h = 0, e = 0, d = 0, dn;
        bit          rh, re, rd;
        int          m_l = 0, m_f = -1, eng_cnt = 0, fails_here = 0, nreq;
        logic [1:0]  m_op = 2'b00, m_wop = 2'b00, nop;
        logic [10:0] m_idx = 11'd0, m_widx = 11'd0, idx;
        logic [19:0] want;
        apply_reset;
        for (int c = 0; c < n_cycles; c++) begin
            if (c > 0) next_cyc;
            want = vec(m_active && c == m_l, m_active ? m_op : 2'b00, m_active ? m_idx : 11'd0,
                       m_active && c == m_f && m_op == 2'b01, m_active && c == m_f && m_op == 2'b10,
                       m_active && c == m_f && m_op == 2'b11, m_active || m_wv, m_tout, m_ovf);
            checks++;
            if (obs !== want) begin
                failures++; fails_here++;
                $display("FAIL random_cycle c=%0d got=%05h want=%05h", c, obs, want);
            end
            if (fails_here >= 10) break;
            // Engine behaviour: answer 1..10 cycles after launch, plus stray pulses.
            dn = 1'b0;
            if (m_active && c == m_l) begin
                eng_cnt = $urandom_range(1, 10);
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) dn = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) dn = 1'b1;
            if ($urandom_range(0, 5) == 0) h = !h;
            if ($urandom_range(0, 5) == 0) e = !e;
            if ($urandom_range(0, 5) == 0) d = !d;
            idx = 11'($urandom);
            set_in(h, e, d, idx, dn);
            // Reference model update for this cycle's inputs.
            rh = h && !ph; re = e && !pe; rd = d && !pd;
            ph = h; pe = e; pd = d;
            nreq = int'(rh) + int'(re) + int'(rd);
            if (nreq > 1) m_ovf = 1'b1;
            nop = rh ? 2'b01 : (re ? 2'b10 : (rd ? 2'b11 : 2'b00));
            if (m_active) begin
                fin = (c == m_f);
                if (m_f < 0 && c > m_l) begin
                    if (dn) begin
                        m_f = c + 1;
                    end else if (c == m_l + TMO) begin
                        m_f = c + 1;
                        m_tout = 1'b1;
                    end
                end
                if (nreq > 0) begin
                    if (!m_wv) begin m_wv = 1'b1; m_wop = nop; m_widx = idx; end
                    else m_ovf = 1'b1;
                end
                if (fin) m_active = 1'b0;
            end else if (m_wv) begin
                m_active = 1'b1; m_l = c + 1; m_f = -1; m_op = m_wop; m_idx = m_widx;
                if (nreq > 0) begin m_wop = nop; m_widx = idx; end
                else m_wv = 1'b0;
            end else if (nreq > 0) begin
                m_active = 1'b1; m_l = c + 1; m_f = -1; m_op = nop; m_idx = idx;
            end
        end
    endtask

    // Scenario sequence and final report
    initial begin
        test_reset;
        test_single_hash;
        test_held_level;
        test_pending_drop;
        test_simultaneous;
        test_timeout;
        test_reset_mid_op;
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
